// File: rtl/div_ctrl_if.sv
// Request/response handshake bundle between the EX stage and div_ctrl.
//   master : the issuing pipeline stage (drives requests, accepts results)
//   slave  : div_ctrl
interface div_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;     // 00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_op, req_x, req_y, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the iterative radix-2 divider.
// Accepts one div/mod request, holds the divider enabled for ITER_CYCLES
// cycles, captures quotient or remainder and returns it on a valid/ready
// port. Divide-by-zero is answered without using the divider; a flush
// abandons whatever is in flight.
// Optional feature: define DIV_RESULT_CACHE_EN for a single-entry operand
// cache that answers a repeated {x, y, signedness} without re-running.
module div_ctrl #(
  parameter int unsigned ITER_CYCLES = 33
) (
  input  logic        clk_div,
  input  logic        rstn,
  input  logic        WB_flush_csr,
  div_ctrl_if.slave   bus,
  output logic        dp_en,
  output logic [31:0] dp_x,
  output logic [31:0] dp_y,
  output logic        dp_signed,
  input  logic [31:0] dp_quo,
  input  logic [31:0] dp_rem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(ITER_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic        is_mod;
  logic [31:0] resp_data_q;

  logic        req_fire;
  logic        resp_fire;
  logic        div_zero;
  logic        capture;
  logic        cache_hit;
  logic [31:0] cache_data;

  // Handshake qualifiers; ready is gated by rstn so it reads 0 while in reset.
  assign bus.req_ready  = (state == IDLE) & ~WB_flush_csr & rstn;
  assign req_fire       = bus.req_valid & bus.req_ready;
  assign resp_fire      = bus.resp_valid & bus.resp_ready;
  assign div_zero       = (bus.req_y == 32'h0);
  assign capture        = (state == CAPT) & ~WB_flush_csr;

  // State-decoded outputs: dp_en follows the state flop, so an async reset
  // drops it immediately.
  assign dp_en          = (state == RUN);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = resp_data_q;

`ifdef DIV_RESULT_CACHE_EN
  logic        c_valid;
  logic [31:0] c_x;
  logic [31:0] c_y;
  logic        c_signed;
  logic [31:0] c_quo;
  logic [31:0] c_rem;

  // Entries are written only from CAPT, so a hit always has a non-zero divisor.
  assign cache_hit  = c_valid & (c_x == bus.req_x) & (c_y == bus.req_y) &
                      (c_signed == ~bus.req_op[1]);
  assign cache_data = bus.req_op[0] ? c_rem : c_quo;

  // Entry valid bit: set on every capture, cleared only by reset (results
  // are pure functions of the operands, so flush leaves the entry alone).
  always_ff @(posedge clk_div or negedge rstn) begin
    if (!rstn) begin
      c_valid <= 1'b0;
    end else if (capture) begin
      c_valid <= 1'b1;
    end
  end

  // Entry payload.
  // NOTE: payload flops carry no reset; c_valid alone guards their use, so
  // resetting them would only add reset routing.
  always_ff @(posedge clk_div) begin
    if (capture) begin
      c_x      <= dp_x;
      c_y      <= dp_y;
      c_signed <= dp_signed;
      c_quo    <= dp_quo;
      c_rem    <= dp_rem;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 32'h0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_div or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides everything.
  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (WB_flush_csr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (req_fire) state_nxt = (div_zero || cache_hit) ? RESP : RUN;
        RUN:  if (cnt == CNT_LAST) state_nxt = CAPT;
        CAPT: state_nxt = RESP;
        RESP: if (resp_fire) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Iteration counter: cleared on accept, flush and RUN exit.
  always_ff @(posedge clk_div or negedge rstn) begin
    if (!rstn) begin
      cnt <= 6'd0;
    end else if (WB_flush_csr || req_fire) begin
      cnt <= 6'd0;
    end else if (state == RUN) begin
      cnt <= (cnt == CNT_LAST) ? 6'd0 : cnt + 6'd1;
    end
  end

  // Operand registers: change only on an accepted request.
  always_ff @(posedge clk_div or negedge rstn) begin
    if (!rstn) begin
      dp_x      <= 32'h0;
      dp_y      <= 32'h0;
      dp_signed <= 1'b0;
      is_mod    <= 1'b0;
    end else if (req_fire) begin
      dp_x      <= bus.req_x;
      dp_y      <= bus.req_y;
      dp_signed <= ~bus.req_op[1];
      is_mod    <= bus.req_op[0];
    end
  end

  // Result register: short-circuit values on accept, divider output in CAPT.
  always_ff @(posedge clk_div or negedge rstn) begin
    if (!rstn) begin
      resp_data_q <= 32'h0;
    end else if (req_fire && div_zero) begin
      resp_data_q <= bus.req_op[0] ? bus.req_x : 32'hFFFF_FFFF;
    end else if (req_fire && cache_hit) begin
      resp_data_q <= cache_data;
    end else if (capture) begin
      resp_data_q <= is_mod ? dp_rem : dp_quo;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed testbench for div_ctrl. A behavioural stand-in for the divider
// drives dp_quo/dp_rem from the registered operands; all expected results
// and latencies are hand-computed constants.
module tb_div_ctrl;

  logic        clk_div = 1'b0;
  logic        rstn;
  logic        WB_flush_csr;
  logic        dp_en;
  logic [31:0] dp_x;
  logic [31:0] dp_y;
  logic        dp_signed;
  logic [31:0] dp_quo;
  logic [31:0] dp_rem;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DIV_RESULT_CACHE_EN
  localparam int REPEAT_LAT = 1;
  localparam int REPEAT_EN  = 0;
`else
  localparam int REPEAT_LAT = 35;
  localparam int REPEAT_EN  = 33;
`endif

  div_ctrl_if bus ();

  div_ctrl #(.ITER_CYCLES(33)) dut (
    .clk_div      (clk_div),
    .rstn         (rstn),
    .WB_flush_csr (WB_flush_csr),
    .bus          (bus),
    .dp_en        (dp_en),
    .dp_x         (dp_x),
    .dp_y         (dp_y),
    .dp_signed    (dp_signed),
    .dp_quo       (dp_quo),
    .dp_rem       (dp_rem)
  );

  always #5 clk_div = ~clk_div;

  // Divider stand-in: truncating division via magnitudes, returns {quo, rem}.
  function automatic logic [63:0] model_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
    logic        neg_x, neg_y;
    logic [31:0] ax, ay, q, r;
    if (y == 32'h0) return 64'h0;
    neg_x = sgn & x[31];
    neg_y = sgn & y[31];
    ax = neg_x ? -x : x;
    ay = neg_y ? -y : y;
    q  = ax / ay;
    r  = ax % ay;
    if (neg_x ^ neg_y) q = -q;
    if (neg_x) r = -r;
    return {q, r};
  endfunction

  assign {dp_quo, dp_rem} = model_div(dp_x, dp_y, dp_signed);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request with resp_ready=1 and check latency, enable count, data.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_en);
    int lat;
    int en;
    @(negedge clk_div);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_x      = x;
    bus.req_y      = y;
    bus.resp_ready = 1'b1;
    lat = 0;
    en  = 0;
    do begin
      @(negedge clk_div);
      bus.req_valid = 1'b0;
      lat++;
      if (dp_en) en++;
    end while (!bus.resp_valid && lat < 100);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dp_en_cycles"}, 32'(en), 32'(exp_en));
    check({tag, "_data"}, bus.resp_data, exp_data);
    @(negedge clk_div);
    check({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    rstn           = 1'b0;
    WB_flush_csr   = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_x      = 32'h0;
    bus.req_y      = 32'h0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_div);
    check("rst_req_ready",  32'(bus.req_ready),  32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_dp_en",      32'(dp_en),          32'd0);
    check("rst_dp_x",       dp_x,                32'h0);
    check("rst_dp_y",       dp_y,                32'h0);
    check("rst_dp_signed",  32'(dp_signed),      32'd0);
    check("rst_resp_data",  bus.resp_data,       32'h0);
    rstn = 1'b1;
    @(negedge clk_div);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // Normal path, signed
    run_op("divw_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 33);
    check("divw_hold_x", dp_x, 32'hFFFF_FFF9);
    check("divw_hold_signed", 32'(dp_signed), 32'd1);

    // Unsigned pair on the same operands (second may hit the cache)
    run_op("modwu_ff_10", 2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5, 35, 33);
    run_op("divwu_ff_10", 2'b10, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, REPEAT_LAT, REPEAT_EN);

    // Divide-by-zero short circuit
    run_op("divw_by0", 2'b00, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1, 0);
    run_op("modw_by0", 2'b01, 32'h0000_1234, 32'h0, 32'h0000_1234, 1, 0);

    // Signed overflow passes straight through
    run_op("divw_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 33);
    run_op("modw_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, REPEAT_LAT, REPEAT_EN);

    // Flush together with req_valid: not accepted
    @(negedge clk_div);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_x     = 32'd100;
    bus.req_y     = 32'd7;
    WB_flush_csr  = 1'b1;
    #1;
    check("flush_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk_div);
    bus.req_valid = 1'b0;
    WB_flush_csr  = 1'b0;
    check("flush_req_dp_en", 32'(dp_en), 32'd0);
    check("flush_req_resp_valid", 32'(bus.resp_valid), 32'd0);

    // Flush in RUN cycle 20
    @(negedge clk_div);
    bus.req_valid = 1'b1;
    @(negedge clk_div);
    bus.req_valid = 1'b0;
    repeat (19) @(negedge clk_div);
    check("flush_run_dp_en_c20", 32'(dp_en), 32'd1);
    WB_flush_csr = 1'b1;
    @(negedge clk_div);
    WB_flush_csr = 1'b0;
    #1;
    check("flush_run_dp_en_c21", 32'(dp_en), 32'd0);
    check("flush_run_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("flush_run_req_ready", 32'(bus.req_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_div);
      if (bus.resp_valid || dp_en) seen = 1'b1;
    end
    check("flush_run_quiet", 32'(seen), 32'd0);
    run_op("modw_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 33);

    // Backpressure: resp_ready low 10 cycles after resp_valid
    @(negedge clk_div);
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'b00;
    bus.req_x      = 32'd100;
    bus.req_y      = 32'd7;
    bus.resp_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_div);
      bus.req_valid = 1'b0;
      lat++;
    end while (!bus.resp_valid && lat < 100);
    check("bp_latency", 32'(lat), 32'd35);
    repeat (10) begin
      @(negedge clk_div);
      check("bp_valid_held", 32'(bus.resp_valid), 32'd1);
      check("bp_data_stable", bus.resp_data, 32'd14);
      check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk_div);
    check("bp_valid_drop", 32'(bus.resp_valid), 32'd0);

    // Asynchronous reset mid-RUN
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_x     = 32'd50;
    bus.req_y     = 32'd3;
    @(negedge clk_div);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk_div);
    check("arst_dp_en_before", 32'(dp_en), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_dp_en",      32'(dp_en),          32'd0);
    check("arst_req_ready",  32'(bus.req_ready),  32'd0);
    check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("arst_dp_x",       dp_x,                32'h0);
    check("arst_resp_data",  bus.resp_data,       32'h0);
    @(negedge clk_div);
    rstn = 1'b1;
    @(negedge clk_div);
    check("arst_release_ready", 32'(bus.req_ready), 32'd1);
    run_op("divwu_50_3", 2'b10, 32'd50, 32'd3, 32'd16, 35, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
